vga_mem_arbiter: RTL and testbench
==================================

Name: vga_mem_arbiter

Overview:
- Shares one single-port synchronous board/tile RAM between two requesters:
  - the VGA pixel-fetch path, driven from the 800x600@60 timing generator's counters and blank;
  - game-logic writes from the Hnefatafl move engine.
- The display always wins, so its read latency is fixed.
- Game writes are buffered in a small FIFO and drained in cycles the display does not use, optionally only during blanking to prevent tearing.

Parameters:
- AW, 8, RAM address width (board tiles plus sprite table).
- DW, 8, RAM data width.
- FIFO_LOG2, 2, log2 of write FIFO depth (depth 4).
- BLANK_ONLY, 1, 1 = drain writes only while blank=1; 0 = drain in any idle display cycle.

Ports:
- pixel_clk  in  1  pixel clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- blank  in  1  registered blank from the timing generator (1 = outside the visible region).
- disp_req  in  1  display read request, one per cycle maximum.
- disp_addr  in  AW  display read address.
- disp_valid  out  1  disp_data valid.
- disp_data  out  DW  read data returned to the display.
- wr_valid  in  1  game write request.
- wr_ready  out  1  FIFO can accept a write.
- wr_addr  in  AW  write address.
- wr_data  in  DW  write data.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid one cycle after mem_en with mem_we=0.
- fifo_level  out  FIFO_LOG2+1  current FIFO occupancy.
- stall_cnt  out  16  saturating count of cycles with wr_valid=1 and wr_ready=0.

Behaviour:
- Reset, synchronous when rst=1:
  - FIFO emptied, fifo_level=0, wr_ready=0 during the reset cycle, 1 from the first cycle after rst falls.
  - disp_valid=0, disp_data=0, stall_cnt=0, FSM returns to IDLE.
  - Pending reads are discarded. Any buffered writes are lost.
- FSM per cycle (state register records the grant issued this cycle):
  - IDLE: no RAM access.
  - DISP: display read granted.
  - WR: FIFO head written.
  - Next grant is decided combinationally each cycle:
    - disp_req=1 -> DISP.
    - else FIFO non-empty and (BLANK_ONLY=0 or blank=1) -> WR.
    - else IDLE.
  - Display priority is absolute. No write can preempt or delay a display read.
- RAM drive (combinational from the grant, same cycle):
  - DISP: mem_en=1, mem_we=0, mem_addr=disp_addr.
  - WR: mem_en=1, mem_we=1, mem_addr and mem_wdata from the FIFO head. Pop occurs at the end of the cycle.
  - IDLE: mem_en=0, mem_we=0. mem_addr and mem_wdata hold their last values.
- Display latency is exactly 2 cycles:
  - disp_req at cycle N -> RAM reads at N -> mem_rdata at N+1 -> registered into disp_data with disp_valid=1 at N+2.
  - A 2-stage valid shift register tracks this.
  - Back-to-back requests give back-to-back valid data.
  - disp_data holds its value when disp_valid=0.
- Write FIFO:
  - Circular buffer of 2^FIFO_LOG2 entries.
  - Read and write pointers are FIFO_LOG2 bits and wrap modulo depth. Occupancy counter is FIFO_LOG2+1 bits.
  - Push when wr_valid&&wr_ready. wr_ready = (fifo_level < depth), registered-equivalent from the current level.
  - When full, wr_ready=0 even if a pop occurs the same cycle; no bypass.
  - Simultaneous push and pop: level unchanged, both pointers advance.
  - Writes retire in strict FIFO order. A write does not forward to an outstanding display read of the same address; the display sees the old value until the write retires.
- stall_cnt increments on each cycle with wr_valid=1 and wr_ready=0, saturating at 16'hFFFF.
- BLANK_ONLY=1:
  - Writes never reach RAM while blank=0.
  - If blank falls while the FIFO is non-empty, draining stops after the current cycle's grant.
- BLANK_ONLY=0: continuous disp_req can starve writes indefinitely. This is intended; the FIFO backpressures the game logic.

Test Plan:
- Reset: after rst is released, wr_ready=1, fifo_level=0, disp_valid=0, mem_en=0. Assert rst while the FIFO holds 3 entries and disp_valid=1 -> next cycle fifo_level=0 and disp_valid=0, and no mem_we pulse follows.
- Display latency: RAM preloaded with addr 0x10=0xA5 and 0x11=0x3C; disp_req at cycles 5 and 6 with addresses 0x10, 0x11 -> disp_valid=1 with disp_data=0xA5 at cycle 7 and 0x3C at cycle 8.
- Blank-gated drain (BLANK_ONLY=1): push writes (0x20,0x11) and (0x21,0x22) while blank=0 -> mem_we stays 0. Raise blank -> mem_we=1 on two consecutive cycles, addresses 0x20 then 0x21, after which fifo_level=0.
- Priority collision (BLANK_ONLY=0, blank=1): FIFO holds one write while disp_req=1 for 3 cycles -> 3 DISP grants, then the write is issued in cycle 4; display data stays correct throughout.
- Full/backpressure: push 4 writes with blank=0 and BLANK_ONLY=1 -> fifo_level=4 and wr_ready=0. Hold wr_valid for 10 more cycles -> stall_cnt=10. Raise blank -> wr_ready returns to 1 the cycle after the first pop.
- Wrap-around: push and drain 9 writes in order (addresses 0x00..0x08) -> RAM contents match and retire order is preserved across pointer wrap.

Source files
------------

// File: rtl/vga_mem_arbiter.sv
// Single-port RAM arbiter: display reads always win and have a fixed 2-cycle latency.
// Game-logic writes are buffered in a small FIFO and retired in idle (optionally blank) cycles.
module vga_mem_arbiter #(
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 8,
  parameter int unsigned FIFO_LOG2 = 2,
  parameter bit          BLANK_ONLY = 1'b1
) (
  input  logic                 pixel_clk,
  input  logic                 rst,
  input  logic                 blank,
  input  logic                 disp_req,
  input  logic [AW-1:0]        disp_addr,
  output logic                 disp_valid,
  output logic [DW-1:0]        disp_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  output logic [FIFO_LOG2:0]   fifo_level,
  output logic [15:0]          stall_cnt
);

  localparam int unsigned Depth = 2 ** FIFO_LOG2;

  typedef enum logic [1:0] {StIdle, StDisp, StWr} state_e;

  state_e               state_q, grant;
  logic [AW-1:0]        fifo_addr_q [Depth];
  logic [DW-1:0]        fifo_data_q [Depth];
  logic [FIFO_LOG2-1:0] rd_ptr_q, wr_ptr_q;
  logic [FIFO_LOG2:0]   level_q;
  logic [AW-1:0]        addr_hold_q;
  logic [DW-1:0]        wdata_hold_q;
  logic                 disp_valid_q;
  logic [DW-1:0]        disp_data_q;
  logic [15:0]          stall_q;
  logic                 push, pop, fifo_empty, drain_ok;

  // Level can only reach Depth when its MSB is set, so the MSB alone flags full.
  assign wr_ready   = ~rst & ~level_q[FIFO_LOG2];
  assign fifo_empty = (level_q == '0);
  assign drain_ok   = ~fifo_empty & (~BLANK_ONLY | blank);
  assign push       = wr_valid & wr_ready;
  assign pop        = (grant == StWr);

  assign fifo_level = level_q;
  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;
  assign stall_cnt  = stall_q;

  always_comb begin
    grant = StIdle;
    if (rst) begin
      grant = StIdle;
    end else if (disp_req) begin
      grant = StDisp;
    end else if (drain_ok) begin
      grant = StWr;
    end
  end

  always_comb begin
    mem_en    = (grant != StIdle);
    mem_we    = (grant == StWr);
    mem_addr  = addr_hold_q;
    mem_wdata = wdata_hold_q;
    unique case (grant)
      StDisp: mem_addr = disp_addr;
      StWr: begin
        mem_addr  = fifo_addr_q[rd_ptr_q];
        mem_wdata = fifo_data_q[rd_ptr_q];
      end
      default: ;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= wr_addr;
      fifo_data_q[wr_ptr_q] <= wr_data;
    end
  end

  // state_q == StDisp is the first stage of the read-valid pipe (RAM data arriving).
  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      level_q      <= '0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= '0;
      stall_q      <= '0;
    end else begin
      state_q <= grant;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop) begin
        level_q <= level_q + 1'b1;
      end else if (pop && !push) begin
        level_q <= level_q - 1'b1;
      end
      if (grant != StIdle) begin
        addr_hold_q  <= mem_addr;
        wdata_hold_q <= mem_wdata;
      end
      disp_valid_q <= (state_q == StDisp);
      if (state_q == StDisp) disp_data_q <= mem_rdata;
      if (wr_valid && !wr_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: two instances (blank-gated and free drain) with behavioural RAMs,
// a read/write scoreboard on the blank-gated one and vector tables for FIFO behaviour.
module tb_vga_mem_arbiter;

  logic       pixel_clk = 1'b0;
  logic       rst = 1'b1;
  logic       blank = 1'b0;
  logic       disp_req = 1'b0;
  logic [7:0] disp_addr = '0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_addr = '0;
  logic [7:0] wr_data = '0;

  logic       disp_valid_a, wr_ready_a, mem_en_a, mem_we_a;
  logic [7:0] disp_data_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic [2:0] fifo_level_a;
  logic [15:0] stall_cnt_a;
  logic       disp_valid_b, wr_ready_b, mem_en_b, mem_we_b;
  logic [7:0] disp_data_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic [2:0] fifo_level_b;
  logic [15:0] stall_cnt_b;

  logic [7:0] ram_a [256];
  logic [7:0] ram_b [256];
  logic [7:0] model_a [256];

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {logic [7:0] addr; logic [7:0] data;} wr_t;
  logic [7:0] rd_q [$];
  wr_t        wq [$];

  typedef struct {
    logic blank, wv;
    logic [7:0] addr, data;
    logic exp_we;
    int   exp_lvl;
    logic exp_rdy;
  } vec_t;
  vec_t vecs [$];

  vga_mem_arbiter #(.AW(8), .DW(8), .FIFO_LOG2(2), .BLANK_ONLY(1'b1)) dut_a (
    .pixel_clk(pixel_clk), .rst(rst), .blank(blank), .disp_req(disp_req),
    .disp_addr(disp_addr), .disp_valid(disp_valid_a), .disp_data(disp_data_a),
    .wr_valid(wr_valid), .wr_ready(wr_ready_a), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_rdata(mem_rdata_a), .fifo_level(fifo_level_a), .stall_cnt(stall_cnt_a)
  );

  vga_mem_arbiter #(.AW(8), .DW(8), .FIFO_LOG2(2), .BLANK_ONLY(1'b0)) dut_b (
    .pixel_clk(pixel_clk), .rst(rst), .blank(blank), .disp_req(disp_req),
    .disp_addr(disp_addr), .disp_valid(disp_valid_b), .disp_data(disp_data_b),
    .wr_valid(wr_valid), .wr_ready(wr_ready_b), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata_b), .fifo_level(fifo_level_b), .stall_cnt(stall_cnt_b)
  );

  always #5 pixel_clk = ~pixel_clk;

  always @(posedge pixel_clk) begin
    if (mem_en_a) begin
      if (mem_we_a) ram_a[mem_addr_a] <= mem_wdata_a;
      else          mem_rdata_a <= ram_a[mem_addr_a];
    end
    if (mem_en_b) begin
      if (mem_we_b) ram_b[mem_addr_b] <= mem_wdata_b;
      else          mem_rdata_b <= ram_b[mem_addr_b];
    end
  end

  function automatic logic [7:0] init_val(input int i);
    if (i == 16'h10) return 8'hA5;
    if (i == 16'h11) return 8'h3C;
    return 8'(i * 7 + 3);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic half();
    @(negedge pixel_clk);
  endtask

  task automatic req_rd(input logic [7:0] a);
    disp_req  = 1'b1;
    disp_addr = a;
    rd_q.push_back(model_a[a]);
  endtask

  task automatic push_wr(input logic [7:0] a, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wq.push_back('{addr: a, data: d});
  endtask

  function automatic void add_vec(input logic b, input logic wv, input logic [7:0] a,
                                  input logic [7:0] d, input logic we, input int lvl,
                                  input logic rdy);
    vecs.push_back('{b, wv, a, d, we, lvl, rdy});
  endfunction

  // Scoreboard for the blank-gated instance.
  always @(negedge pixel_clk) begin
    wr_t w;
    if (!rst) begin
      if (disp_valid_a) begin
        chk("rd_pending", int'(rd_q.size() != 0), 1);
        if (rd_q.size() != 0) chk("rd_data", disp_data_a, rd_q.pop_front());
      end
      if (mem_en_a && mem_we_a) begin
        chk("wr_in_blank", blank, 1);
        chk("wr_pending", int'(wq.size() != 0), 1);
        if (wq.size() != 0) begin
          w = wq.pop_front();
          chk("wr_addr", mem_addr_a, w.addr);
          chk("wr_data", mem_wdata_a, w.data);
          model_a[w.addr] = w.data;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  pushed;
    bit  done;
    for (int i = 0; i < 256; i++) begin
      ram_a[i]   = init_val(i);
      ram_b[i]   = init_val(i);
      model_a[i] = init_val(i);
    end

    // Reset state
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    half();
    chk("rst_wr_ready", wr_ready_a, 1);
    chk("rst_level", fifo_level_a, 0);
    chk("rst_disp_valid", disp_valid_a, 0);
    chk("rst_disp_data", disp_data_a, 0);
    chk("rst_mem_en", mem_en_a, 0);
    chk("rst_stall", stall_cnt_a, 0);
    chk("rst_wr_ready_b", wr_ready_b, 1);

    // Display latency: back-to-back reads
    tick(); req_rd(8'h10); half();
    chk("lat_mem_en", mem_en_a, 1);
    chk("lat_mem_addr", mem_addr_a, 8'h10);
    tick(); req_rd(8'h11); half();
    chk("lat_valid_n1", disp_valid_a, 0);
    tick(); disp_req = 1'b0; half();
    chk("lat_valid_n2", disp_valid_a, 1);
    chk("lat_data_n2", disp_data_a, 8'hA5);
    tick(); half();
    chk("lat_valid_n3", disp_valid_a, 1);
    chk("lat_data_n3", disp_data_a, 8'h3C);
    tick(); half();
    chk("lat_valid_n4", disp_valid_a, 0);
    chk("lat_data_hold", disp_data_a, 8'h3C);

    // Blank-gated drain, then full / backpressure
    add_vec(0, 1, 8'h20, 8'h11, 0, 0, 1);
    add_vec(0, 1, 8'h21, 8'h22, 0, 1, 1);
    add_vec(0, 0, 8'h00, 8'h00, 0, 2, 1);
    add_vec(1, 0, 8'h00, 8'h00, 1, 2, 1);
    add_vec(1, 0, 8'h00, 8'h00, 1, 1, 1);
    add_vec(1, 0, 8'h00, 8'h00, 0, 0, 1);
    add_vec(0, 0, 8'h00, 8'h00, 0, 0, 1);
    for (int i = 0; i < 4; i++) add_vec(0, 1, 8'(8'h30 + i), 8'(8'hA0 + i), 0, i, 1);
    for (int i = 0; i < 10; i++) add_vec(0, 1, 8'h34, 8'hA4, 0, 4, 0);
    add_vec(1, 0, 8'h00, 8'h00, 1, 4, 0);
    add_vec(1, 0, 8'h00, 8'h00, 1, 3, 1);
    add_vec(1, 0, 8'h00, 8'h00, 1, 2, 1);
    add_vec(1, 0, 8'h00, 8'h00, 1, 1, 1);
    add_vec(1, 0, 8'h00, 8'h00, 0, 0, 1);
    add_vec(0, 0, 8'h00, 8'h00, 0, 0, 1);
    foreach (vecs[i]) begin
      tick();
      blank    = vecs[i].blank;
      wr_valid = vecs[i].wv;
      wr_addr  = vecs[i].addr;
      wr_data  = vecs[i].data;
      if (vecs[i].wv && vecs[i].exp_rdy) wq.push_back('{addr: vecs[i].addr, data: vecs[i].data});
      half();
      chk($sformatf("vec%0d_we", i), mem_we_a, vecs[i].exp_we);
      chk($sformatf("vec%0d_level", i), fifo_level_a, vecs[i].exp_lvl);
      chk($sformatf("vec%0d_ready", i), wr_ready_a, vecs[i].exp_rdy);
    end
    chk("stall_cnt", stall_cnt_a, 10);

    // Reset with 3 buffered writes and a read in flight
    tick(); wr_valid = 1'b0; blank = 1'b0; push_wr(8'h50, 8'hB0); half();
    tick(); push_wr(8'h51, 8'hB1); req_rd(8'h11); half();
    tick(); push_wr(8'h52, 8'hB2); disp_req = 1'b0; half();
    tick(); wr_valid = 1'b0; rst = 1'b1; rd_q.delete(); wq.delete(); half();
    chk("rst2_pre_valid", disp_valid_a, 1);
    chk("rst2_pre_level", fifo_level_a, 3);
    tick(); rst = 1'b0; blank = 1'b1; half();
    chk("rst2_level", fifo_level_a, 0);
    chk("rst2_valid", disp_valid_a, 0);
    chk("rst2_data", disp_data_a, 0);
    chk("rst2_ready", wr_ready_a, 1);
    for (int i = 0; i < 4; i++) begin
      tick(); half();
      chk($sformatf("rst2_no_we%0d", i), mem_we_a, 0);
    end

    // Priority collision on the free-drain instance (blank=1)
    tick(); push_wr(8'h40, 8'h77); req_rd(8'h10); half();
    chk("col0_en", mem_en_b, 1);
    chk("col0_we", mem_we_b, 0);
    chk("col0_addr", mem_addr_b, 8'h10);
    tick(); wr_valid = 1'b0; req_rd(8'h11); half();
    chk("col1_we", mem_we_b, 0);
    chk("col1_level", fifo_level_b, 1);
    tick(); req_rd(8'h40); half();
    chk("col2_we", mem_we_b, 0);
    chk("col2_addr", mem_addr_b, 8'h40);
    chk("col2_valid", disp_valid_b, 1);
    chk("col2_data", disp_data_b, 8'hA5);
    tick(); disp_req = 1'b0; half();
    chk("col3_we", mem_we_b, 1);
    chk("col3_addr", mem_addr_b, 8'h40);
    chk("col3_wdata", mem_wdata_b, 8'h77);
    chk("col3_data", disp_data_b, 8'h3C);
    tick(); half();
    chk("col4_en", mem_en_b, 0);
    chk("col4_addr_hold", mem_addr_b, 8'h40);
    chk("col4_level", fifo_level_b, 0);
    chk("col4_valid", disp_valid_b, 1);
    chk("col4_old_data", disp_data_b, init_val(8'h40));
    tick(); req_rd(8'h40); half();
    tick(); disp_req = 1'b0; half();
    tick(); half();
    chk("col7_valid", disp_valid_b, 1);
    chk("col7_new_data", disp_data_b, 8'h77);

    // Wrap-around: 9 writes through the 4-deep FIFO, then read back
    pushed = 0;
    done   = 1'b0;
    blank  = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      tick();
      blank = (pushed >= 4);
      if (pushed < 9) begin
        wr_valid = 1'b1;
        wr_addr  = 8'(pushed);
        wr_data  = 8'(8'hC0 + pushed);
      end else begin
        wr_valid = 1'b0;
      end
      half();
      if (wr_valid && wr_ready_a) begin
        wq.push_back('{addr: wr_addr, data: wr_data});
        pushed++;
      end
      done = (pushed == 9) && (wq.size() == 0) && (fifo_level_a == 0);
    end
    chk("wrap_done", done, 1);
    tick(); wr_valid = 1'b0; half();
    for (int i = 0; i < 9; i++) begin
      tick(); req_rd(8'(i)); half();
    end
    tick(); disp_req = 1'b0; half();
    repeat (3) begin
      tick(); half();
    end
    chk("rd_q_drained", rd_q.size(), 0);
    chk("wq_drained", wq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
